// File: rtl/tri_pkg.sv
// Shared types and width helpers for the point-in-triangle pipeline.
// Widths derive from the coordinate width W of the instantiating module.
package tri_pkg;

    typedef enum logic [1:0] {
        VTX0 = 2'd0,
        VTX1 = 2'd1,
        VTX2 = 2'd2
    } vtx_slot_t;

    // Coordinate differences: one sign bit on top of the unsigned range
    function automatic int dw_of(input int w);
        return w + 1;
    endfunction

    // Products of two differences
    function automatic int pw_of(input int w);
        return 2 * w + 2;
    endfunction

    // Difference of two products
    function automatic int cw_of(input int w);
        return 2 * w + 3;
    endfunction

endpackage

// File: rtl/tri_edge_cross.sv
// One edge function of the triangle test: differences (stage 1), products
// (stage 2), and the combinational cross product c = ex*dy - ey*dx.
module tri_edge_cross
    import tri_pkg::*;
#(
    parameter int W = 11
) (
    input  logic                        clk,
    input  logic                        adv,
    input  logic [W-1:0]                vi_x,
    input  logic [W-1:0]                vi_y,
    input  logic [W-1:0]                vj_x,
    input  logic [W-1:0]                vj_y,
    input  logic [W-1:0]                px,
    input  logic [W-1:0]                py,
    output logic signed [cw_of(W)-1:0]  c
);

    localparam int DW = dw_of(W);
    localparam int PW = pw_of(W);
    localparam int CW = cw_of(W);

    logic signed [DW-1:0] ex_reg, ey_reg, dx_reg, dy_reg;
    logic signed [PW-1:0] p_reg, q_reg;
    logic signed [PW-1:0] ex_ext, ey_ext, dx_ext, dy_ext;

    always_ff @(posedge clk) begin
        if (adv) begin
            ex_reg <= $signed({1'b0, vj_x}) - $signed({1'b0, vi_x});
            ey_reg <= $signed({1'b0, vj_y}) - $signed({1'b0, vi_y});
            dx_reg <= $signed({1'b0, px})   - $signed({1'b0, vi_x});
            dy_reg <= $signed({1'b0, py})   - $signed({1'b0, vi_y});
        end
    end

    // Sign-extend before multiplying so the full-width product is exact
    assign ex_ext = PW'(ex_reg);
    assign ey_ext = PW'(ey_reg);
    assign dx_ext = PW'(dx_reg);
    assign dy_ext = PW'(dy_reg);

    always_ff @(posedge clk) begin
        if (adv) begin
            p_reg <= ex_ext * dy_ext;
            q_reg <= ey_ext * dx_ext;
        end
    end

    assign c = CW'(p_reg) - CW'(q_reg);

endmodule

// File: rtl/tri_inside_pipe.sv
// Pipelined point-in-triangle tester: vertex loading, valid/degenerate
// tracking, three parallel edge functions and the final sign combine.
module tri_inside_pipe
    import tri_pkg::*;
#(
    parameter int W               = 11,
    parameter bit BOUNDARY_INSIDE = 1'b1
) (
    input  logic         clk,
    input  logic         r,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         in_vtx,
    input  logic [W-1:0] in_x,
    input  logic [W-1:0] in_y,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         out_inside,
    output logic         out_degen,
    output logic         tri_ok
);

    localparam int CW = cw_of(W);

    vtx_slot_t      vcnt_reg, vcnt_next;
    logic           tri_ok_reg, tri_ok_next;
    logic           commit;

    logic [W-1:0]   stg_x_reg [2];
    logic [W-1:0]   stg_y_reg [2];
    logic [W-1:0]   act_x_reg [3];
    logic [W-1:0]   act_y_reg [3];

    logic           adv, accept, vtx_acc, pt_acc;

    logic [2:0]     v_reg;
    logic [2:0]     nl_reg;
    logic           out_valid_reg, out_inside_reg, out_degen_reg;

    logic signed [CW-1:0] c_w   [3];
    logic signed [CW-1:0] c_reg [3];
    logic [2:0]     c_pos, c_neg, c_zero;
    logic           pos_all, neg_all, degen_w, inside_w;

    assign adv     = ~out_valid_reg | out_ready;
    assign accept  = in_valid & adv;
    assign vtx_acc = accept & in_vtx;
    assign pt_acc  = accept & ~in_vtx;

    // Vertex slot sequencing
    always_ff @(posedge clk or posedge r) begin
        if (r) begin
            vcnt_reg   <= VTX0;
            tri_ok_reg <= 1'b0;
        end else begin
            vcnt_reg   <= vcnt_next;
            tri_ok_reg <= tri_ok_next;
        end
    end

    always_comb begin
        vcnt_next   = vcnt_reg;
        tri_ok_next = tri_ok_reg;
        commit      = 1'b0;
        if (vtx_acc) begin
            case (vcnt_reg)
                VTX0: vcnt_next = VTX1;
                VTX1: vcnt_next = VTX2;
                VTX2: begin
                    vcnt_next   = VTX0;
                    tri_ok_next = 1'b1;
                    commit      = 1'b1;
                end
                default: vcnt_next = VTX0;
            endcase
        end
    end

    // Triangle data needs no reset: tri_ok gates its use
    always_ff @(posedge clk) begin
        if (vtx_acc && vcnt_reg == VTX0) begin
            stg_x_reg[0] <= in_x;
            stg_y_reg[0] <= in_y;
        end
        if (vtx_acc && vcnt_reg == VTX1) begin
            stg_x_reg[1] <= in_x;
            stg_y_reg[1] <= in_y;
        end
        if (commit) begin
            act_x_reg[0] <= stg_x_reg[0];
            act_y_reg[0] <= stg_y_reg[0];
            act_x_reg[1] <= stg_x_reg[1];
            act_y_reg[1] <= stg_y_reg[1];
            act_x_reg[2] <= in_x;
            act_y_reg[2] <= in_y;
        end
    end

    // Points sample the currently active set, so a commit on the same edge
    // only affects later points.
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_edge
            tri_edge_cross #(
                .W (W)
            ) u_edge (
                .clk  (clk),
                .adv  (adv),
                .vi_x (act_x_reg[gi]),
                .vi_y (act_y_reg[gi]),
                .vj_x (act_x_reg[(gi + 1) % 3]),
                .vj_y (act_y_reg[(gi + 1) % 3]),
                .px   (in_x),
                .py   (in_y),
                .c    (c_w[gi])
            );

            assign c_neg[gi]  = c_reg[gi][CW-1];
            assign c_zero[gi] = (c_reg[gi] == '0);
            assign c_pos[gi]  = ~c_reg[gi][CW-1] & ~c_zero[gi];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (adv) begin
            for (int i = 0; i < 3; i++) begin
                c_reg[i] <= c_w[i];
            end
        end
    end

    assign pos_all  = BOUNDARY_INSIDE ? &(c_pos | c_zero) : &c_pos;
    assign neg_all  = BOUNDARY_INSIDE ? &(c_neg | c_zero) : &c_neg;
    assign degen_w  = (&c_zero) | nl_reg[2];
    assign inside_w = (pos_all | neg_all) & ~degen_w;

    // nl_reg marks points accepted before any triangle was committed
    always_ff @(posedge clk or posedge r) begin
        if (r) begin
            v_reg          <= '0;
            nl_reg         <= '0;
            out_valid_reg  <= 1'b0;
            out_inside_reg <= 1'b0;
            out_degen_reg  <= 1'b0;
        end else if (adv) begin
            v_reg         <= {v_reg[1:0], pt_acc};
            nl_reg        <= {nl_reg[1:0], ~tri_ok_reg};
            out_valid_reg <= v_reg[2];
            if (v_reg[2]) begin
                out_inside_reg <= inside_w;
                out_degen_reg  <= degen_w;
            end
        end
    end

    assign in_ready   = adv;
    assign out_valid  = out_valid_reg;
    assign out_inside = out_inside_reg;
    assign out_degen  = out_degen_reg;
    assign tri_ok     = tri_ok_reg;

endmodule

// File: tb/tb_tri_inside_pipe.sv
// Scoreboard bench for tri_inside_pipe: two instances (edge counts inside
// and edge counts outside) share stimulus and are checked verdict by verdict.
module tb_tri_inside_pipe;

    localparam int W = 11;

    logic         clk = 1'b0;
    logic         r = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_vtx = 1'b0;
    logic [W-1:0] in_x = '0;
    logic [W-1:0] in_y = '0;
    logic         out_ready = 1'b1;

    logic in_ready1, out_valid1, out_inside1, out_degen1, tri_ok1;
    logic in_ready0, out_valid0, out_inside0, out_degen0, tri_ok0;

    tri_inside_pipe #(.W(W), .BOUNDARY_INSIDE(1'b1)) dut1 (
        .clk(clk), .r(r), .in_valid(in_valid), .in_ready(in_ready1),
        .in_vtx(in_vtx), .in_x(in_x), .in_y(in_y),
        .out_valid(out_valid1), .out_ready(out_ready),
        .out_inside(out_inside1), .out_degen(out_degen1), .tri_ok(tri_ok1)
    );

    tri_inside_pipe #(.W(W), .BOUNDARY_INSIDE(1'b0)) dut0 (
        .clk(clk), .r(r), .in_valid(in_valid), .in_ready(in_ready0),
        .in_vtx(in_vtx), .in_x(in_x), .in_y(in_y),
        .out_valid(out_valid0), .out_ready(out_ready),
        .out_inside(out_inside0), .out_degen(out_degen0), .tri_ok(tri_ok0)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int n_out    = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model of the loaded triangle
    typedef struct {
        bit in1;
        bit in0;
        bit dg;
        int px;
        int py;
    } exp_t;

    exp_t sbq[$];
    int   mx[3], my[3], sx[2], sy[2];
    int   mvcnt   = 0;
    bit   mtri_ok = 1'b0;

    function automatic exp_t model(input int px, input int py);
        exp_t   e;
        longint c[3];
        bit     ge, le, gt, lt, zz;
        for (int i = 0; i < 3; i++) begin
            int j = (i + 1) % 3;
            c[i] = longint'(mx[j] - mx[i]) * longint'(py - my[i])
                 - longint'(my[j] - my[i]) * longint'(px - mx[i]);
        end
        ge = (c[0] >= 0) && (c[1] >= 0) && (c[2] >= 0);
        le = (c[0] <= 0) && (c[1] <= 0) && (c[2] <= 0);
        gt = (c[0] > 0)  && (c[1] > 0)  && (c[2] > 0);
        lt = (c[0] < 0)  && (c[1] < 0)  && (c[2] < 0);
        zz = (c[0] == 0) && (c[1] == 0) && (c[2] == 0);
        e.dg  = zz || !mtri_ok;
        e.in1 = (ge || le) && !e.dg;
        e.in0 = (gt || lt) && !e.dg;
        e.px  = px;
        e.py  = py;
        return e;
    endfunction

    // Backpressure pattern: 1,0,0 repeating when enabled
    bit bp_mode = 1'b0;
    int bp_idx  = 0;
    always @(posedge clk) begin
        #2;
        if (bp_mode) begin
            out_ready = (bp_idx % 3 == 0);
            bp_idx++;
        end else begin
            out_ready = 1'b1;
        end
    end

    // Output monitor: pops on handshake, checks hold during stalls
    bit   hold_pend = 1'b0;
    logic h_in1, h_dg1, h_in0, h_dg0;
    always @(negedge clk) begin
        if (r) begin
            hold_pend = 1'b0;
        end else begin
            check("valid_match", out_valid0, out_valid1);
            if (hold_pend) begin
                check("hold_valid", out_valid1, 1);
                check("hold_inside_b1", out_inside1, h_in1);
                check("hold_degen_b1", out_degen1, h_dg1);
                check("hold_inside_b0", out_inside0, h_in0);
                check("hold_degen_b0", out_degen0, h_dg0);
                hold_pend = 1'b0;
            end
            if (out_valid1 && !out_ready) begin
                hold_pend = 1'b1;
                h_in1 = out_inside1;
                h_dg1 = out_degen1;
                h_in0 = out_inside0;
                h_dg0 = out_degen0;
            end
            if (out_valid1 && out_ready) begin
                if (sbq.size() == 0) begin
                    check("stale_verdict", 1, 0);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    n_out++;
                    $display("verdict %0d: pt=(%0d,%0d) inside_b1=%0d inside_b0=%0d degen=%0d exp=%0d/%0d/%0d",
                             n_out, e.px, e.py, out_inside1, out_inside0, out_degen1, e.in1, e.in0, e.dg);
                    check("inside_b1", out_inside1, e.in1);
                    check("inside_b0", out_inside0, e.in0);
                    check("degen_b1", out_degen1, e.dg);
                    check("degen_b0", out_degen0, e.dg);
                end
            end
        end
    end

    task automatic send(input bit vtx, input int x, input int y);
        int waited = 0;
        @(negedge clk);
        #1;
        in_valid = 1'b1;
        in_vtx   = vtx;
        in_x     = W'(x);
        in_y     = W'(y);
        while (!in_ready1) begin
            @(negedge clk);
            #1;
            waited++;
            if (waited > 100) begin
                check("send_timeout", 1, 0);
                in_valid = 1'b0;
                return;
            end
        end
        if (vtx) begin
            if (mvcnt < 2) begin
                sx[mvcnt] = x;
                sy[mvcnt] = y;
                mvcnt++;
            end else begin
                mx[0] = sx[0]; my[0] = sy[0];
                mx[1] = sx[1]; my[1] = sy[1];
                mx[2] = x;     my[2] = y;
                mtri_ok = 1'b1;
                mvcnt   = 0;
            end
        end else begin
            sbq.push_back(model(x, y));
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic load_tri(input int x0, input int y0, input int x1, input int y1,
                            input int x2, input int y2);
        send(1'b1, x0, y0);
        send(1'b1, x1, y1);
        send(1'b1, x2, y2);
    endtask

    task automatic drain();
        int k = 0;
        while (sbq.size() != 0 && k < 300) begin
            @(negedge clk);
            k++;
        end
        check("drain_timeout", sbq.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid1, 0);
        check("rst_out_inside", out_inside1, 0);
        check("rst_out_degen", out_degen1, 0);
        check("rst_tri_ok", tri_ok1, 0);
        @(negedge clk);
        r = 1'b0;
        #1;
        check("rst_in_ready", in_ready1, 1);

        // Point before any triangle
        send(1'b0, 3, 3);
        drain();

        // Right triangle; tri_ok only after the third vertex
        send(1'b1, 0, 0);
        send(1'b1, 10, 0);
        check("tri_ok_partial", tri_ok1, 0);
        send(1'b1, 0, 10);
        check("tri_ok_commit", tri_ok1, 1);

        // Latency: verdict visible after the third edge following acceptance
        send(1'b0, 2, 2);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("latency_early", out_valid1, 0);
        @(posedge clk); #1;
        check("latency_hit", out_valid1, 1);
        drain();

        send(1'b0, 10, 10);
        send(1'b0, 5, 5);
        send(1'b0, 0, 0);
        send(1'b0, 11, 0);
        drain();

        // Clockwise winding, then collinear
        load_tri(0, 0, 0, 10, 10, 0);
        send(1'b0, 2, 2);
        send(1'b0, 9, 9);
        load_tri(0, 0, 5, 5, 10, 10);
        send(1'b0, 3, 3);
        send(1'b0, 3, 4);
        drain();

        // Full-range triangle
        load_tri(0, 0, 2047, 0, 0, 2047);
        send(1'b0, 1, 1);
        send(1'b0, 2047, 2047);
        send(1'b0, 2047, 0);
        send(1'b0, 1023, 1024);
        send(1'b0, 1024, 1024);
        drain();

        // Backpressure with a triangle swap mid-stream
        bp_mode = 1'b1;
        for (int i = 0; i < 4; i++) send(1'b0, $urandom_range(0, 2047), $urandom_range(0, 2047));
        load_tri(0, 0, 100, 0, 0, 100);
        for (int i = 0; i < 4; i++) send(1'b0, $urandom_range(0, 120), $urandom_range(0, 120));
        drain();
        bp_mode = 1'b0;

        // Random points against a general triangle
        load_tri(40, 10, 200, 90, 60, 180);
        for (int i = 0; i < 12; i++) send(1'b0, $urandom_range(0, 220), $urandom_range(0, 200));
        drain();

        // Reset with two points in flight
        send(1'b0, 50, 50);
        send(1'b0, 300, 300);
        r = 1'b1;
        #1;
        check("midrst_out_valid", out_valid1, 0);
        check("midrst_tri_ok", tri_ok1, 0);
        sbq.delete();
        mvcnt   = 0;
        mtri_ok = 1'b0;
        repeat (2) @(negedge clk);
        r = 1'b0;
        repeat (8) @(negedge clk);
        #1;
        check("post_rst_idle", out_valid1, 0);
        send(1'b0, 1, 1);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/tri_inside_pipe.md
# tri_inside_pipe

Parametrised, fully pipelined point-in-triangle tester for the rasteriser path. A triangle is loaded as three vertex beats and then held. Any number of test-point beats may follow; each produces one inside/outside verdict. All three edge functions are evaluated in parallel, so the verdict does not depend on winding order. A valid/ready handshake on both sides supports backpressure.

## Interface
Parameters:
- W, 11: unsigned coordinate width in bits (4..16).
- BOUNDARY_INSIDE, 1: 1 = a point exactly on an edge counts as inside; 0 = it counts as outside.

Ports:
- clk  in  1  clock; every register updates on the rising edge.
- r  in  1  reset, asynchronous and active-high.
- in_valid  in  1  input beat valid.
- in_ready  out  1  input beat accepted when in_valid && in_ready.
- in_vtx  in  1  1 = beat is a triangle vertex; 0 = beat is a test point.
- in_x, in_y  in  W  unsigned coordinates.
- out_valid  out  1  verdict valid.
- out_ready  in  1  downstream accepts the verdict.
- out_inside  out  1  point is inside the triangle.
- out_degen  out  1  triangle is degenerate or was never loaded; out_inside is forced to 0.
- tri_ok  out  1  a full triangle has been committed.

## Operation
- Vertex loading: a 2-bit vcnt selects the slot 0, 1 or 2 for each accepted vertex beat.
  - Slots 0 and 1 write staging registers.
  - The slot-2 beat commits all three vertices to the active triangle set in the same edge, sets tri_ok and resets vcnt to 0.
  - Vertex beats never produce an output.
- Test points:
  - An accepted point enters stage 1 together with the active triangle set, so the next triangle may load while earlier points are still in flight.
  - A point accepted in the same cycle as the slot-2 commit uses the old triangle.
- Stage 1 computes, for edges i = 0..2 with j = (i+1) mod 3:
  - ex_i = vx_j − vx_i, ey_i = vy_j − vy_i, dx_i = px − vx_i, dy_i = py − vy_i.
  - Each is signed, W+1 bits, registered.
- Stage 2 computes p_i = ex_i·dy_i and q_i = ey_i·dx_i. Each is signed, 2W+2 bits, registered.
- Stage 3:
  - c_i = p_i − q_i, signed, 2W+3 bits; no overflow is possible.
  - pos = all c_i > 0; neg = all c_i < 0.
  - With BOUNDARY_INSIDE=1: pos = all c_i ≥ 0, neg = all c_i ≤ 0.
  - degen = all c_i == 0, or tri_ok was 0 when the point was accepted.
  - out_inside = (pos | neg) & ~degen. The result is registered into the output stage.
- Reset mid-operation clears vcnt, tri_ok, all stage valids, out_valid, out_inside and out_degen. In-flight points are dropped and produce no verdict.

## Timing
- Reset values: in_ready=1 once r deasserts, out_valid=0, out_inside=0, out_degen=0, tri_ok=0.
- Latency: a point accepted at edge N gives out_valid=1 after edge N+3 when there is no stall. Throughput is 1 point per cycle.
- Pipeline advance: adv = ~out_valid | out_ready. All stages shift only when adv=1.
- in_ready = adv, combinational. Vertex beats obey the same in_ready.
- Bubbles: stage valid bits propagate empty slots, and out_valid never asserts for a bubble.
- Hold under stall: while out_valid=1 && out_ready=0, out_inside and out_degen hold stable and no beat is accepted.
- Simultaneous events: an output pop and an input accept in the same cycle are legal and expected.

## Structure
- Shared package tri_pkg:
  - Localparam width functions: DW = W+1, PW = 2W+2, CW = 2W+3.
  - Vertex-slot enum VTX0/VTX1/VTX2.
- One sub-module, tri_edge_cross, instantiated 3 times:
  - Inputs: one edge's vertices plus the point.
  - Registers stages 1–2 under the shared adv and outputs c_i.
  - The top level keeps vertex loading, valid tracking and the stage-3 combine.

## Test plan
- Triangle (0,0),(10,0),(0,10), then point (2,2) → out_inside=1, out_degen=0, 3 cycles after acceptance; point (10,10) → out_inside=0.
- Same triangle, point (5,5) on the hypotenuse → out_inside=1 with BOUNDARY_INSIDE=1, and 0 with BOUNDARY_INSIDE=0. Vertex (0,0) → out_inside=BOUNDARY_INSIDE.
- Clockwise order (0,0),(0,10),(10,0) with point (2,2) → out_inside=1. Collinear (0,0),(5,5),(10,10) with point (3,3) → out_degen=1, out_inside=0.
- W=11 with vertices (0,0),(2047,0),(0,2047):
  - Point (1,1) → 1; point (2047,2047) → 0.
  - Intermediate values stay within CW bits with no wrap.
- Backpressure:
  - Stream 8 points back-to-back with out_ready toggling 1,0,0,1,… → 8 verdicts in order, no loss or duplication, and outputs stable during stalls.
  - A new triangle loaded mid-stream applies only to points accepted after its slot-2 commit.
- Point sent before any triangle → out_degen=1. Assert r mid-stream with 2 points in flight → out_valid=0 immediately, tri_ok=0, no stale verdicts after release.
